// File: rtl/range_scanner.sv
// range_scanner: round-robin ultrasonic ranging over NUM_CH sensors.
// Each channel gets one slot: trigger pulse, wait for echo, time the echo
// in microseconds, then hold off until the slot ends. Results are kept per
// channel and one of them is shown on a bargraph.
module range_scanner #(
   parameter int unsigned CLK_HZ        = 40000000,
   parameter int unsigned NUM_CH        = 4,
   parameter int unsigned W             = 16,
   parameter int unsigned SLOT_US       = 60000,
   parameter int unsigned TRIG_US       = 10,
   parameter int unsigned NUM_LEDS      = 8,
   parameter int unsigned FULL_SCALE_US = 3552,
   localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_CH-1:0]   echo,
   output logic [NUM_CH-1:0]   trig,
   input  logic [CW-1:0]       led_sel,
   output logic [NUM_LEDS-1:0] led,
   output logic [W-1:0]        dist_us,
   output logic [CW-1:0]       dist_ch,
   output logic                dist_valid,
   output logic                dist_timeout
);

   localparam int unsigned DIV = CLK_HZ / 1000000;
   localparam int unsigned PW  = $clog2(DIV);
   localparam int unsigned SW  = $clog2(SLOT_US + 1);

   typedef enum logic [1:0] {S_TRIG, S_WAIT_RISE, S_MEASURE, S_HOLDOFF} state_t;

   state_t            state;
   logic [CW-1:0]     ch;
   logic [CW-1:0]     ch_next;
   logic [NUM_CH-1:0] ch_oh;
   logic [NUM_CH-1:0] next_oh;
   logic [SW-1:0]     slot_cnt;
   logic [W-1:0]      echo_cnt;
   logic [W-1:0]      result [NUM_CH];
   logic [PW-1:0]     pre_cnt;
   logic              us_tick;
   logic [NUM_CH-1:0] echo_m;
   logic [NUM_CH-1:0] echo_s;
   logic              echo_act;
   logic              slot_end;
   logic              trig_done;
   logic              rep_en;
   logic [W-1:0]      rep_val;
   logic              rep_to;
   logic [W-1:0]      sel_res;

   // Microsecond prescaler: one-cycle us_tick every DIV clocks
   always_ff @(posedge clk) begin
      if (!reset_n)
         pre_cnt <= '0;
      else if (pre_cnt == PW'(DIV - 1))
         pre_cnt <= '0;
      else
         pre_cnt <= pre_cnt + 1'b1;
   end

   assign us_tick = (pre_cnt == PW'(DIV - 1));

   // Two-flop synchroniser for the asynchronous echo lines
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         echo_m <= '0;
         echo_s <= '0;
      end else begin
         echo_m <= echo;
         echo_s <= echo_m;
      end
   end

   // Select the synchronised echo of the channel currently being serviced
   always_comb begin
      echo_act = 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++)
         if (ch == CW'(c)) echo_act = echo_s[c];
   end

   assign slot_end  = us_tick && (slot_cnt == SW'(SLOT_US - 1));
   assign trig_done = us_tick && (slot_cnt == SW'(TRIG_US - 1));
   assign ch_next   = (ch == CW'(NUM_CH - 1)) ? '0 : ch + 1'b1;
   assign ch_oh     = NUM_CH'(1) << ch;
   assign next_oh   = NUM_CH'(1) << ch_next;

   // Report decision: slot end beats an echo rise, an echo fall beats slot end
   always_comb begin
      rep_en  = 1'b0;
      rep_val = '0;
      rep_to  = 1'b0;
      case (state)
         S_WAIT_RISE: if (slot_end) begin
            rep_en  = 1'b1;
            rep_val = '1;
            rep_to  = 1'b1;
         end
         S_MEASURE: if (!echo_act) begin
            rep_en  = 1'b1;
            rep_val = echo_cnt;
         end else if (slot_end) begin
            rep_en  = 1'b1;
            rep_val = '1;
            rep_to  = 1'b1;
         end
         default: ;
      endcase
   end

   // Slot FSM with registered trigger, report outputs and per-channel results
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= S_TRIG;
         ch           <= '0;
         slot_cnt     <= '0;
         echo_cnt     <= '0;
         trig         <= '0;
         dist_valid   <= 1'b0;
         dist_us      <= '0;
         dist_ch      <= '0;
         dist_timeout <= 1'b0;
         for (int unsigned c = 0; c < NUM_CH; c++) result[c] <= '0;
      end else begin
         dist_valid <= 1'b0;
         if (us_tick) slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;

         case (state)
            S_TRIG: begin
               if (trig_done) begin
                  trig  <= '0;
                  state <= S_WAIT_RISE;
               end else begin
                  trig <= ch_oh;
               end
            end
            S_WAIT_RISE: begin
               if (slot_end) begin
                  state <= S_TRIG;
                  ch    <= ch_next;
                  trig  <= next_oh;
               end else if (echo_act) begin
                  state    <= S_MEASURE;
                  echo_cnt <= '0;
               end
            end
            S_MEASURE: begin
               if (slot_end) begin
                  state <= S_TRIG;
                  ch    <= ch_next;
                  trig  <= next_oh;
               end else if (!echo_act) begin
                  state <= S_HOLDOFF;
               end else if (us_tick && (echo_cnt != '1)) begin
                  echo_cnt <= echo_cnt + 1'b1;
               end
            end
            S_HOLDOFF: begin
               if (slot_end) begin
                  state <= S_TRIG;
                  ch    <= ch_next;
                  trig  <= next_oh;
               end
            end
            default: state <= S_TRIG;
         endcase

         if (rep_en) begin
            dist_valid   <= 1'b1;
            dist_us      <= rep_val;
            dist_ch      <= ch;
            dist_timeout <= rep_to;
            for (int unsigned c = 0; c < NUM_CH; c++)
               if (ch == CW'(c)) result[c] <= rep_val;
         end
      end
   end

   // Bargraph of the selected channel's result; out-of-range selection is dark
   always_comb begin
      sel_res = '0;
      for (int unsigned c = 0; c < NUM_CH; c++)
         if (led_sel == CW'(c)) sel_res = result[c];
      for (int unsigned i = 0; i < NUM_LEDS; i++)
         led[i] = (32'(sel_res) > (i * FULL_SCALE_US) / NUM_LEDS);
   end

endmodule

// File: tb/tb_range_scanner.sv
// Randomized self-checking bench for range_scanner with a scaled-down
// timing configuration plus a narrow-result instance for saturation.
module tb_range_scanner;

   localparam int DIV   = 2;
   localparam int NCH   = 4;
   localparam int SLOT  = 1000;
   localparam int TRIGW = 10;
   localparam int NLED  = 8;
   localparam int FS    = 800;
   localparam longint ALL1 = 65535;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // main instance
   logic            reset_n;
   logic [NCH-1:0]  drive = '0;
   logic [NCH-1:0]  noise = '0;
   logic [NCH-1:0]  echo;
   logic [NCH-1:0]  trig;
   logic [1:0]      led_sel = '0;
   logic [NLED-1:0] led;
   logic [15:0]     dist_us;
   logic [1:0]      dist_ch;
   logic            dist_valid;
   logic            dist_timeout;

   assign echo = drive | noise;

   range_scanner #(
      .CLK_HZ(2000000), .NUM_CH(NCH), .W(16), .SLOT_US(SLOT),
      .TRIG_US(TRIGW), .NUM_LEDS(NLED), .FULL_SCALE_US(FS)
   ) dut (
      .clk(clk), .reset_n(reset_n), .echo(echo), .trig(trig),
      .led_sel(led_sel), .led(led), .dist_us(dist_us), .dist_ch(dist_ch),
      .dist_valid(dist_valid), .dist_timeout(dist_timeout)
   );

   // narrow instance: 8-bit result, 3 channels
   logic       reset_n8;
   logic [2:0] echo8;
   logic [2:0] trig8;
   logic [1:0] led_sel8;
   logic [7:0] led8;
   logic [7:0] dist_us8;
   logic [1:0] dist_ch8;
   logic       dist_valid8;
   logic       dist_timeout8;
   bit         done8 = 0;

   range_scanner #(
      .CLK_HZ(2000000), .NUM_CH(3), .W(8), .SLOT_US(600),
      .TRIG_US(10), .NUM_LEDS(8), .FULL_SCALE_US(3552)
   ) dut_w8 (
      .clk(clk), .reset_n(reset_n8), .echo(echo8), .trig(trig8),
      .led_sel(led_sel8), .led(led8), .dist_us(dist_us8), .dist_ch(dist_ch8),
      .dist_valid(dist_valid8), .dist_timeout(dist_timeout8)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input longint obs, input longint exp,
                        input longint tol = 0);
      n_checks++;
      if (obs >= exp - tol && obs <= exp + tol) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
   endtask

   // reference model state
   longint res_model [NCH];
   int     exp_ch     = 0;
   bit     fresh      = 1;
   bit     prev_fresh = 0;
   int     prev_rise  = 0;
   int     release_cyc = 0;

   function automatic logic [NLED-1:0] led_model(input longint r);
      logic [NLED-1:0] v;
      for (int i = 0; i < NLED; i++) v[i] = (r > (i * FS) / NLED);
      return v;
   endfunction

   // trigger edge monitor
   int             rise_q [$];
   logic [NCH-1:0] oh_q [$];
   int             width_q [$];
   logic [NCH-1:0] trig_prev = '0;
   int             rise_t = 0;

   always @(negedge clk) begin
      if (trig_prev == '0 && trig != '0) begin
         rise_q.push_back(cyc);
         oh_q.push_back(trig);
         rise_t = cyc;
      end
      if (trig_prev != '0 && trig == '0) width_q.push_back(cyc - rise_t);
      trig_prev = trig;
   end

   task automatic step_noise(input int act);
      int k;
      if ($urandom_range(0, 99) == 0) begin
         k = $urandom_range(0, NCH - 1);
         if (k != act) noise[k] = ~noise[k];
      end
   endtask

   task automatic idle(input int n, input int act);
      repeat (n) begin
         @(negedge clk);
         step_noise(act);
      end
   endtask

   task automatic wait_report(input int budget, input int act, output bit got);
      got = 0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (dist_valid) got = 1;
         else step_noise(act);
      end
   endtask

   task automatic get_trig(output int ch, output bit ok);
      bit got;
      int t_rise;
      int w;
      logic [NCH-1:0] oh;
      ok = 0;
      ch = 0;
      got = 0;
      for (int i = 0; i < SLOT * DIV + 100 && !got; i++) begin
         if (rise_q.size() > 0) got = 1;
         else @(negedge clk);
      end
      check("trig_rise_seen", got, 1);
      if (!got) return;
      t_rise = rise_q.pop_front();
      oh = oh_q.pop_front();
      check("trig_onehot", $countones(oh), 1);
      for (int c = 0; c < NCH; c++) if (oh[c]) ch = c;
      check("trig_channel", ch, exp_ch);
      if (fresh) check("trig_after_reset", (t_rise - release_cyc <= DIV), 1);
      else check("trig_period", t_rise - prev_rise, SLOT * DIV, prev_fresh ? DIV : 0);
      got = 0;
      for (int i = 0; i < TRIGW * DIV + 20 && !got; i++) begin
         if (width_q.size() > 0) got = 1;
         else @(negedge clk);
      end
      check("trig_fall_seen", got, 1);
      if (!got) return;
      w = width_q.pop_front();
      check("trig_width", w, TRIGW * DIV, fresh ? DIV : 0);
      prev_fresh = fresh;
      fresh = 0;
      prev_rise = t_rise;
      exp_ch = (ch + 1) % NCH;
      ok = 1;
   endtask

   // mode: 0 none, 1 pulse of l_us after d_us, 2 echo held past slot end
   task automatic do_slot(input int mode, input int d_us, input int l_us, input int sel);
      int ch;
      bit ok;
      bit got;
      longint exp_us;
      logic [15:0] held_us;
      get_trig(ch, ok);
      if (!ok) return;
      got = 0;
      case (mode)
         1: begin
            idle(d_us * DIV, ch);
            drive[ch] = 1'b1;
            idle(l_us * DIV, ch);
            drive[ch] = 1'b0;
            wait_report(30, ch, got);
            exp_us = l_us;
         end
         2: begin
            idle(d_us * DIV, ch);
            drive[ch] = 1'b1;
            wait_report(SLOT * DIV, ch, got);
            drive[ch] = 1'b0;
            exp_us = ALL1;
         end
         default: begin
            wait_report(SLOT * DIV + 20, ch, got);
            exp_us = ALL1;
         end
      endcase
      noise = '0;
      check("report_seen", got, 1);
      if (!got) return;
      check("dist_ch", dist_ch, ch);
      check("dist_timeout", dist_timeout, (mode == 1) ? 0 : 1);
      check("dist_us", dist_us, exp_us, (mode == 1) ? 1 : 0);
      res_model[ch] = exp_us;
      led_sel = 2'(sel);
      #1;
      check("led", led, led_model(res_model[sel]));
      held_us = dist_us;
      @(negedge clk);
      check("valid_one_cycle", dist_valid, 0);
      check("dist_us_held", dist_us, held_us);
   endtask

   task automatic random_slot();
      int mode;
      int d;
      int l;
      mode = $urandom_range(0, 9);
      d = $urandom_range(5, 100);
      l = $urandom_range(5, 850);
      if (l % 100 == 1) l++;
      do_slot((mode < 2) ? 0 : (mode == 2) ? 2 : 1, d, l, $urandom_range(0, NCH - 1));
   endtask

   task automatic reset_mid();
      int ch;
      bit ok;
      get_trig(ch, ok);
      if (!ok) return;
      idle(50 * DIV, ch);
      drive[ch] = 1'b1;
      idle(200 * DIV, ch);
      reset_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("rst_mid_valid", dist_valid, 0);
      end
      check("rst_mid_trig", trig, 0);
      check("rst_mid_dist_us", dist_us, 0);
      check("rst_mid_dist_ch", dist_ch, 0);
      check("rst_mid_timeout", dist_timeout, 0);
      check("rst_mid_led", led, 0);
      drive = '0;
      noise = '0;
      for (int c = 0; c < NCH; c++) res_model[c] = 0;
      rise_q.delete();
      oh_q.delete();
      width_q.delete();
      exp_ch = 0;
      fresh = 1;
      reset_n = 1'b1;
      release_cyc = cyc;
   endtask

   initial begin : main_proc
      bit got;
      reset_n = 1'b0;
      for (int c = 0; c < NCH; c++) res_model[c] = 0;
      repeat (4) @(negedge clk);
      check("rst_trig", trig, 0);
      check("rst_valid", dist_valid, 0);
      check("rst_dist_us", dist_us, 0);
      check("rst_dist_ch", dist_ch, 0);
      check("rst_timeout", dist_timeout, 0);
      check("rst_led", led, 0);
      reset_n = 1'b1;
      release_cyc = cyc;

      // full rotation with no echoes: 0,1,2,3,0 all timeouts
      for (int s = 0; s < 5; s++) do_slot(0, 0, 0, $urandom_range(0, NCH - 1));
      do_slot(2, 40, 0, 1);    // ch1 echo held past slot end
      do_slot(1, 50, 800, 2);  // ch2 full-scale pulse
      random_slot();
      random_slot();
      random_slot();
      do_slot(1, 50, 700, 2);  // ch2 one step below full scale
      for (int s = 0; s < 10; s++) random_slot();
      reset_mid();
      for (int s = 0; s < 3; s++) random_slot();

      got = 0;
      for (int i = 0; i < 5000 && !got; i++) begin
         if (done8) got = 1;
         else @(negedge clk);
      end
      check("w8_done", got, 1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin : w8_proc
      bit got;
      reset_n8 = 1'b0;
      echo8 = '0;
      led_sel8 = '0;
      repeat (4) @(negedge clk);
      check("w8_rst_valid", dist_valid8, 0);
      check("w8_rst_trig", trig8, 0);
      reset_n8 = 1'b1;
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (trig8[0]) got = 1;
      end
      check("w8_trig0_rise", got, 1);
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (!trig8[0]) got = 1;
      end
      check("w8_trig0_fall", got, 1);
      repeat (50 * DIV) @(negedge clk);
      echo8[0] = 1'b1;
      repeat (400 * DIV) @(negedge clk);
      echo8[0] = 1'b0;
      got = 0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (dist_valid8) got = 1;
      end
      check("w8_report", got, 1);
      check("w8_dist_us_sat", dist_us8, 255);
      check("w8_timeout", dist_timeout8, 0);
      check("w8_dist_ch", dist_ch8, 0);
      led_sel8 = 2'd0;
      #1;
      check("w8_led_ch0", led8, 8'h01);
      // wait for the timeout reports of channels 1 and 2
      for (int r = 0; r < 2; r++) begin
         got = 0;
         for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (dist_valid8) got = 1;
         end
         check("w8_timeout_report", got, 1);
         check("w8_timeout_flag", dist_timeout8, 1);
         check("w8_timeout_us", dist_us8, 255);
      end
      led_sel8 = 2'd2;
      #1;
      check("w8_led_ch2", led8, 8'h01);
      led_sel8 = 2'd3;
      #1;
      check("w8_led_out_of_range", led8, 0);
      done8 = 1;
   end

endmodule

// File: doc/range_scanner.md
RANGE_SCANNER -- requirements
Module: range_scanner

Interface
REQ-001 Parameter CLK_HZ, default 40000000: input clock frequency in Hz; CLK_HZ/1000000 SHALL be an integer of at least 2.
REQ-002 Parameter NUM_CH, default 4: number of ultrasonic sensor channels, 1 to 8.
REQ-003 Parameter W, default 16: width of the echo-time result in microseconds.
REQ-004 Parameter SLOT_US, default 60000: length of one channel measurement slot in microseconds.
REQ-005 Parameter TRIG_US, default 10: trigger pulse width in microseconds.
REQ-006 Parameter NUM_LEDS, default 8: number of bargraph LEDs.
REQ-007 Parameter FULL_SCALE_US, default 3552: echo time that lights the whole bargraph.
REQ-008 Port clk, input, 1: single system clock, rising-edge.
REQ-009 Port reset_n, input, 1: synchronous active-low reset.
REQ-010 Port echo, input, NUM_CH: asynchronous echo lines, one per sensor.
REQ-011 Port trig, output, NUM_CH: trigger lines, one per sensor.
REQ-012 Port led_sel, input, $clog2(NUM_CH) (min 1): channel shown on the bargraph.
REQ-013 Port led, output, NUM_LEDS: bargraph.
REQ-014 Port dist_us, output, W: latest result.
REQ-015 Port dist_ch, output, $clog2(NUM_CH) (min 1): channel of dist_us.
REQ-016 Port dist_valid, output, 1: one-cycle strobe when dist_us/dist_ch update.
REQ-017 Port dist_timeout, output, 1: qualifies dist_valid; 1 = no valid echo.

Function
REQ-018 A prescaler SHALL pulse an internal us_tick for one clk every CLK_HZ/1000000 cycles; all us timing counts us_tick only.
REQ-019 Each echo bit SHALL pass a 2-flop synchroniser; all FSM decisions use the synchronised value.
REQ-020 Channels SHALL be serviced round-robin, one at a time, 0,1,...,NUM_CH-1, wrapping to 0; only the active channel's trig may be high.
REQ-021 FSM states: TRIG, WAIT_RISE, MEASURE, HOLDOFF; a slot counter counts us_ticks from slot start and ends the slot at SLOT_US.
REQ-022 TRIG: trig[ch]=1 for exactly TRIG_US ticks, then go to WAIT_RISE.
REQ-023 WAIT_RISE: on synchronised echo[ch]=1 go to MEASURE with echo count=0; at slot end go to TRIG of next channel and report a timeout.
REQ-024 MEASURE: increment the echo count on each us_tick while echo high, saturating at 2^W-1; on echo fall report the count (timeout=0) and go to HOLDOFF.
REQ-025 MEASURE at slot end with echo still high: report all-ones with timeout=1, go to TRIG of next channel.
REQ-026 HOLDOFF: wait for slot end, then TRIG of next channel; echo activity ignored.
REQ-027 Reporting: dist_valid=1 for exactly one clk; dist_us, dist_ch, dist_timeout are updated that same cycle and held until the next report.
REQ-028 The per-channel result register SHALL capture each report; a timeout stores all-ones.
REQ-029 led[i] = (result[led_sel] > i*FULL_SCALE_US/NUM_LEDS); division is constant; led[0] is therefore result>0.
REQ-030 led SHALL update combinationally from led_sel and registered results; led_sel >= NUM_CH shows all LEDs off.
REQ-031 Echo rise and slot end on the same tick: slot end wins (timeout report).
REQ-032 Echo fall and slot end on the same tick: the echo fall wins (valid report with the count).

Reset
REQ-033 While reset_n=0 at a clk edge: trig=0, dist_valid=0, dist_us=0, dist_ch=0, dist_timeout=0, all results=0, led=0, prescaler=0, FSM to TRIG of channel 0 with slot counter=0.
REQ-034 Reset mid-slot SHALL abort any measurement without a report; the first trig after release goes to channel 0.
REQ-035 First trig rises within one us_tick after reset_n goes high.

Verification
REQ-036 Defaults; echo[0] high 1000 us, 200 us after the trig fall -> dist_valid with dist_us=1000±1, dist_ch=0, timeout=0; led_sel=0 -> led=8'b0000_0111.
REQ-037 No echo on any channel -> the trig pulses are 10 us wide, 60000 us apart, and in order 0,1,2,3,0; each slot reports timeout=1 with dist_us=16'hFFFF; led is all ones.
REQ-038 W=8, echo high 400 us -> dist_us=255 (saturated), timeout=0.
REQ-039 echo[1] held high past slot end -> timeout report for channel 1; echo toggling on inactive channels leaves the results unchanged.
REQ-040 reset_n low for 3 clks during MEASURE -> no dist_valid, all outputs at reset values, the next trig is on channel 0.
REQ-041 echo pulse of 3552 us on channel 2 and led_sel=2 -> led=8'hFF; 3108 us -> 8'h7F.
